// File: rtl/axi3_rd_arbiter_2to1.sv
// Two-master to one-slave AXI3 read arbiter: one burst at a time, R beats routed to the owner,
// with rid/length checking. Define AXI3_RD_ARB_FIXED_PRIO_EN for fixed m1-first priority.
module axi3_rd_arbiter_2to1 #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 64,
    parameter  int ID_WIDTH   = 4,
    localparam int ARI_W      = ID_WIDTH + ADDR_WIDTH + 18,
    localparam int RI_W       = ID_WIDTH + DATA_WIDTH + 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             arvalid_m1,
    input  logic             arvalid_m2,
    input  logic [ARI_W-1:0] arinfo_m1,
    input  logic [ARI_W-1:0] arinfo_m2,
    output logic             arready_m1,
    output logic             arready_m2,
    output logic             rvalid_m1,
    output logic             rvalid_m2,
    output logic             rlast_m1,
    output logic             rlast_m2,
    output logic [RI_W-1:0]  rinfo_m1,
    output logic [RI_W-1:0]  rinfo_m2,
    input  logic             rready_m1,
    input  logic             rready_m2,
    output logic             arvalid_s1,
    output logic [ARI_W-1:0] arinfo_s1,
    input  logic             arready_s1,
    input  logic             rvalid_s1,
    input  logic             rlast_s1,
    input  logic [RI_W-1:0]  rinfo_s1,
    output logic             rready_s1,
    output logic             owner,
    output logic             busy,
    output logic             rid_err,
    output logic             len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;
    logic [ID_WIDTH-1:0] r_arid_q;
    logic [3:0]          r_arlen_q;
    logic [4:0]          r_beat_cnt;
    logic                r_rid_err;
    logic                r_len_err;

    logic                w_req_any;
    logic                w_pick_m2;
    logic                w_arvalid_sel;
    logic [ARI_W-1:0]    w_arinfo_sel;
    logic                w_rready_sel;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic [ID_WIDTH-1:0] w_rid;
    logic                w_len_ok;

    assign w_req_any     = arvalid_m1 | arvalid_m2;
    assign w_arvalid_sel = r_owner ? arvalid_m2 : arvalid_m1;
    assign w_arinfo_sel  = r_owner ? arinfo_m2  : arinfo_m1;
    assign w_rready_sel  = r_owner ? rready_m2  : rready_m1;
    assign w_ar_hs       = (r_state == ADDR) & w_arvalid_sel & arready_s1;
    assign w_r_hs        = (r_state == DATA) & rvalid_s1 & w_rready_sel;
    assign w_rid         = rinfo_s1[RI_W-1 -: ID_WIDTH];
    assign w_len_ok      = (({1'b0, r_beat_cnt}) + 6'd1) == (({2'b00, r_arlen_q}) + 6'd1);

`ifdef AXI3_RD_ARB_FIXED_PRIO_EN
    assign w_pick_m2 = arvalid_m2 & ~arvalid_m1;
`else
    logic r_last_grant;

    // On a tie, the master that was not granted last time wins.
    assign w_pick_m2 = arvalid_m2 & (~arvalid_m1 | ~r_last_grant);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant <= 1'b1;
        end else if (w_ar_hs) begin
            r_last_grant <= r_owner;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        arvalid_s1 = 1'b0;
        arinfo_s1  = '0;
        arready_m1 = 1'b0;
        arready_m2 = 1'b0;
        rready_s1  = 1'b0;
        rvalid_m1  = 1'b0;
        rvalid_m2  = 1'b0;
        rlast_m1   = 1'b0;
        rlast_m2   = 1'b0;
        rinfo_m1   = '0;
        rinfo_m2   = '0;
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                arvalid_s1 = w_arvalid_sel;
                arinfo_s1  = w_arinfo_sel;
                arready_m1 = ~r_owner & arready_s1;
                arready_m2 = r_owner & arready_s1;
                if (w_ar_hs) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                rready_s1 = w_rready_sel;
                if (r_owner) begin
                    rvalid_m2 = rvalid_s1;
                    rlast_m2  = rlast_s1;
                    rinfo_m2  = rinfo_s1;
                end else begin
                    rvalid_m1 = rvalid_s1;
                    rlast_m1  = rlast_s1;
                    rinfo_m1  = rinfo_s1;
                end
                if (w_r_hs && rlast_s1) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant, burst bookkeeping and registered one-cycle error pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_owner    <= 1'b0;
            r_arid_q   <= '0;
            r_arlen_q  <= '0;
            r_beat_cnt <= '0;
            r_rid_err  <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_rid_err <= w_r_hs & (w_rid != r_arid_q);
            r_len_err <= w_r_hs & rlast_s1 & ~w_len_ok;
            if ((r_state == IDLE) && w_req_any) begin
                r_owner <= w_pick_m2;
            end
            if (w_ar_hs) begin
                r_arid_q   <= w_arinfo_sel[ARI_W-1 -: ID_WIDTH];
                r_arlen_q  <= w_arinfo_sel[17:14];
                r_beat_cnt <= '0;
            end else if (w_r_hs && (r_beat_cnt != 5'd31)) begin
                r_beat_cnt <= r_beat_cnt + 5'd1;
            end
        end
    end

    assign owner   = r_owner;
    assign busy    = (r_state != IDLE);
    assign rid_err = r_rid_err;
    assign len_err = r_len_err;

endmodule
